// File: rtl/decode_stage.sv
// RISC-V decode stage with a registered output slot and a one-entry skid slot.
// Define DECODE_ILLEGAL_CHK_EN to build the illegal-instruction checker.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_imm_sel,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      immSel;
    logic [XLEN-1:0] imm;
  } bundle_t;

  state_t  r_state;
  state_t  w_nextState;
  logic    r_inReady;
  bundle_t r_mainData;
  bundle_t r_skidData;
  bundle_t w_decoded;
  logic [31:0] w_imm32;
  logic    w_accept;
  logic    w_drain;
  logic    w_loadMainIn;
  logic    w_loadMainSkid;
  logic    w_loadSkidIn;

  always_comb begin
    w_imm32          = 32'd0;
    w_decoded        = '0;
    w_decoded.pc     = in_pc;
    w_decoded.opcode = in_instr[6:0];
    w_decoded.func3  = in_instr[14:12];
    w_decoded.func7  = in_instr[31:25];
    w_decoded.rs1    = in_instr[19:15];
    w_decoded.rs2    = in_instr[24:20];
    w_decoded.rd     = in_instr[11:7];
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w_decoded.immSel = 3'd1;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        w_decoded.immSel = 3'd2;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        w_decoded.immSel = 3'd3;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_decoded.immSel = 3'd4;
        w_imm32 = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        w_decoded.immSel = 3'd5;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        w_decoded.immSel = 3'd0;
        w_imm32 = 32'd0;
      end
    endcase
    w_decoded.imm = XLEN'($signed(w_imm32));
  end

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = r_inReady;
  assign w_accept  = in_valid & r_inReady;
  assign w_drain   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != FULL);
    end
  end

  // Flush wins over any concurrent accept or drain and loads nothing.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkidIn   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_nextState  = ONE;
          w_loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_drain) begin
          w_loadMainIn = 1'b1;
        end else if (w_accept) begin
          w_nextState  = FULL;
          w_loadSkidIn = 1'b1;
        end else if (w_drain) begin
          w_nextState = EMPTY;
        end
      end
      FULL: begin
        if (w_drain) begin
          w_nextState    = ONE;
          w_loadMainSkid = 1'b1;
        end
      end
      default: w_nextState = EMPTY;
    endcase
    if (flush) begin
      w_nextState    = EMPTY;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkidIn   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mainData <= '0;
    end else if (w_loadMainIn) begin
      r_mainData <= w_decoded;
    end else if (w_loadMainSkid) begin
      r_mainData <= r_skidData;
    end
  end

  // The skid slot is only ever read after being written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_loadSkidIn) begin
      r_skidData <= w_decoded;
    end
  end

  assign out_pc      = r_mainData.pc;
  assign out_opcode  = r_mainData.opcode;
  assign out_func3   = r_mainData.func3;
  assign out_func7   = r_mainData.func7;
  assign out_rs1     = r_mainData.rs1;
  assign out_rs2     = r_mainData.rs2;
  assign out_rd      = r_mainData.rd;
  assign out_imm_sel = r_mainData.immSel;
  assign out_imm     = r_mainData.imm;

`ifdef DECODE_ILLEGAL_CHK_EN
  logic w_illegal;
  logic r_mainIllegal;
  logic r_skidIllegal;

  always_comb begin
    w_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0110011: begin
        if (!((in_instr[31:25] == 7'b0000000) ||
              ((in_instr[31:25] == 7'b0100000) &&
               ((in_instr[14:12] == 3'b000) || (in_instr[14:12] == 3'b101)))))
          w_illegal = 1'b1;
      end
      7'b0010011: begin
        if ((in_instr[14:12] == 3'b001) && (in_instr[31:25] != 7'b0000000))
          w_illegal = 1'b1;
        if ((in_instr[14:12] == 3'b101) && (in_instr[31:25] != 7'b0000000) &&
            (in_instr[31:25] != 7'b0100000))
          w_illegal = 1'b1;
      end
      7'b1100111: w_illegal = (in_instr[14:12] != 3'b000);
      7'b1100011: w_illegal = (in_instr[14:12] == 3'b010) || (in_instr[14:12] == 3'b011);
      7'b0000011: w_illegal = (in_instr[14:12] == 3'b011) || (in_instr[14:12] == 3'b110) ||
                              (in_instr[14:12] == 3'b111);
      7'b0100011: w_illegal = (in_instr[14:12] > 3'b010);
      7'b0110111, 7'b0010111, 7'b1101111: w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) w_illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mainIllegal <= 1'b0;
    end else if (w_loadMainIn) begin
      r_mainIllegal <= w_illegal;
    end else if (w_loadMainSkid) begin
      r_mainIllegal <= r_skidIllegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_loadSkidIn) begin
      r_skidIllegal <= w_illegal;
    end
  end

  assign out_illegal = r_mainIllegal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal cases plus random
// traffic against a queue-based reference model (XLEN=32 and XLEN=64 instances).
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [31:0] inInstr;
  logic [63:0] inPc64;
  logic [31:0] inPc;
  assign inPc = inPc64[31:0];

  logic        inReady, outValid, outIllegal;
  logic [31:0] outPc, outImm;
  logic [6:0]  outOpcode, outFunc7;
  logic [2:0]  outFunc3, outImmSel;
  logic [4:0]  outRs1, outRs2, outRd;

  logic        inReady64, outValid64, outIllegal64;
  logic [63:0] outPc64, outImm64;
  logic [6:0]  outOpcode64, outFunc764;
  logic [2:0]  outFunc364, outImmSel64;
  logic [4:0]  outRs164, outRs264, outRd64;

  decode_stage #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rstN), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .in_instr(inInstr), .in_pc(inPc), .out_valid(outValid), .out_ready(outReady),
    .out_pc(outPc), .out_opcode(outOpcode), .out_func3(outFunc3), .out_func7(outFunc7),
    .out_rs1(outRs1), .out_rs2(outRs2), .out_rd(outRd), .out_imm_sel(outImmSel),
    .out_imm(outImm), .out_illegal(outIllegal)
  );

  decode_stage #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rstN), .flush(flush), .in_valid(inValid), .in_ready(inReady64),
    .in_instr(inInstr), .in_pc(inPc64), .out_valid(outValid64), .out_ready(outReady),
    .out_pc(outPc64), .out_opcode(outOpcode64), .out_func3(outFunc364), .out_func7(outFunc764),
    .out_rs1(outRs164), .out_rs2(outRs264), .out_rd(outRd64), .out_imm_sel(outImmSel64),
    .out_imm(outImm64), .out_illegal(outIllegal64)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference decode rules, expressed as arithmetic on instruction fields.
  function automatic int refSel(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return 1;
      7'h23:               return 2;
      7'h63:               return 3;
      7'h37, 7'h17:        return 4;
      7'h6F:               return 5;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [63:0] refImm(input logic [31:0] ins);
    longint v;
    case (refSel(ins))
      1: v = $signed(ins[31:20]);
      2: v = $signed({ins[31:25], ins[11:7]});
      3: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
      4: v = $signed(ins[31:12]) * 4096;
      5: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit refIllegal(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_CHK_EN
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    if (ins[1:0] != 2'b11) return 1;
    case (ins[6:0])
      7'h33: return !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      7'h13: return (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
      7'h67: return f3 != 0;
      7'h63: return f3 == 2 || f3 == 3;
      7'h03: return f3 == 3 || f3 == 6 || f3 == 7;
      7'h23: return f3 > 2;
      7'h37, 7'h17, 7'h6F: return 0;
      default: return 1;
    endcase
`else
    return ins[0] & ~ins[0];
`endif
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t modelQ[$];
  entry_t cmpEntry;
  bit     zeroed = 1'b1;
  bit     started = 1'b0;
  bit     doDrain, doAcc;

  // Model: a FIFO of at most two entries; head is what the outputs show.
  always @(posedge clk) begin
    if (!rstN) begin
      modelQ.delete();
      zeroed = 1'b1;
    end else if (flush) begin
      modelQ.delete();
    end else begin
      doDrain = (modelQ.size() > 0) && outReady;
      doAcc   = inValid && (modelQ.size() < 2);
      if (doDrain) void'(modelQ.pop_front());
      if (doAcc) modelQ.push_back('{inInstr, inPc64});
      if (modelQ.size() > 0) zeroed = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("outValid", outValid, modelQ.size() > 0);
      checkOutput("inReady", inReady, modelQ.size() < 2);
      checkOutput("outValid64", outValid64, modelQ.size() > 0);
      if (modelQ.size() > 0) begin
        cmpEntry = modelQ[0];
        checkOutput("outPc", outPc, cmpEntry.pc[31:0]);
        checkOutput("outPc64", outPc64, cmpEntry.pc);
        checkOutput("outOpcode", outOpcode, cmpEntry.instr[6:0]);
        checkOutput("outFunc3", outFunc3, cmpEntry.instr[14:12]);
        checkOutput("outFunc7", outFunc7, cmpEntry.instr[31:25]);
        checkOutput("outRs1", outRs1, cmpEntry.instr[19:15]);
        checkOutput("outRs2", outRs2, cmpEntry.instr[24:20]);
        checkOutput("outRd", outRd, cmpEntry.instr[11:7]);
        checkOutput("outImmSel", outImmSel, 64'(refSel(cmpEntry.instr)));
        checkOutput("outImm", outImm, {32'd0, refImm(cmpEntry.instr) & 64'hFFFF_FFFF});
        checkOutput("outImm64", outImm64, refImm(cmpEntry.instr));
        checkOutput("outIllegal", outIllegal, refIllegal(cmpEntry.instr));
      end else if (zeroed) begin
        checkOutput("rstPc", outPc, 0);
        checkOutput("rstOpcode", outOpcode, 0);
        checkOutput("rstImm", outImm, 0);
        checkOutput("rstImm64", outImm64, 0);
        checkOutput("rstIllegal", outIllegal, 0);
      end
    end
  end

  task automatic applyStimulus(input bit valid, input logic [31:0] instr, input logic [63:0] pc,
                               input bit ready, input bit fl);
    inValid  = valid;
    inInstr  = instr;
    inPc64   = pc;
    outReady = ready;
    flush    = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0] opcTbl [10] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    logic [31:0] ins = $urandom;
    int pick = $urandom_range(0, 9);
    ins[6:0] = (pick == 9) ? 7'($urandom) : opcTbl[pick];
    if ($urandom_range(0, 3) == 0) ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return ins;
  endfunction

  logic [31:0] immInstr [6] = '{32'hFFF10093, 32'h00512423, 32'hFE000EE3,
                                32'h123450B7, 32'hFF9FF06F, 32'h800000B7};
  logic [2:0]  immSel   [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4};
  logic [31:0] immVal32 [6] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC,
                                32'h12345000, 32'hFFFFFFF8, 32'h80000000};
  logic [63:0] immVal64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                                64'h12345000, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000};
  logic [31:0] illInstr [3] = '{32'h00000000, 32'h40001033, 32'h00000033};
`ifdef DECODE_ILLEGAL_CHK_EN
  logic        illExp   [3] = '{1'b1, 1'b1, 1'b0};
`else
  logic        illExp   [3] = '{1'b0, 1'b0, 1'b0};
`endif

  initial begin
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hFFF10093, 64'h40, 0, 0);
      started = 1'b1;
    end
    checkOutput("resetOutValid", outValid, 0);
    checkOutput("resetOutImm", outImm, 0);
    checkOutput("resetOutIllegal", outIllegal, 0);
    rstN = 1'b1;
    applyStimulus(0, 32'h0, 64'h0, 1, 0);
    checkOutput("releaseInReady", inReady, 1);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, immInstr[k], 64'h1000 + 64'(4 * k), 1, 0);
      checkOutput("immValid", outValid, 1);
      checkOutput("immSel", outImmSel, immSel[k]);
      checkOutput("imm32", outImm, immVal32[k]);
      checkOutput("imm64", outImm64, immVal64[k]);
      if (k == 0) begin
        checkOutput("immRs1", outRs1, 2);
        checkOutput("immRd", outRd, 1);
      end
      if (k == 1) checkOutput("immRs2", outRs2, 5);
    end
    applyStimulus(0, 32'h0, 64'h0, 1, 0);

    applyStimulus(1, 32'h00100093, 64'h100, 0, 0);
    applyStimulus(1, 32'h00200113, 64'h104, 0, 0);
    checkOutput("bpReadyLow", inReady, 0);
    applyStimulus(1, 32'h00300193, 64'h108, 0, 0);
    checkOutput("bpHoldPc", outPc, 32'h100);
    checkOutput("bpHoldReady", inReady, 0);
    applyStimulus(1, 32'h00300193, 64'h108, 1, 0);
    checkOutput("bpPcB", outPc, 32'h104);
    checkOutput("bpReadyAgain", inReady, 1);
    applyStimulus(1, 32'h00300193, 64'h108, 1, 0);
    checkOutput("bpPcC", outPc, 32'h108);
    checkOutput("bpValidC", outValid, 1);
    applyStimulus(0, 32'h0, 64'h0, 1, 0);
    checkOutput("bpDrained", outValid, 0);

    applyStimulus(1, 32'h00400213, 64'h200, 0, 0);
    applyStimulus(1, 32'h00500293, 64'h204, 0, 0);
    applyStimulus(1, 32'h00A00093, 64'h208, 1, 1);
    checkOutput("flushValid", outValid, 0);
    checkOutput("flushReady", inReady, 1);
    applyStimulus(0, 32'h0, 64'h0, 1, 0);
    checkOutput("flushDropped", outValid, 0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, illInstr[k], 64'h300 + 64'(4 * k), 1, 0);
      checkOutput("illegalFlag", outIllegal, illExp[k]);
    end
    applyStimulus(0, 32'h0, 64'h0, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      rstN = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 9) < 7, randInstr(), {32'($urandom), 32'($urandom)},
                    $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    rstN = 1'b1;
    applyStimulus(0, 32'h0, 64'h0, 1, 0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0);
    checkOutput("finalEmpty", outValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
